// File: rtl/neuron_bank_if.sv
// Bus between the timestep scheduler (master) and the memory-mapped neuron bank (slave).
// read_data is combinational in the same cycle; busywait stalls any access in progress.
interface neuron_bank_if;
  logic [31:0] addr;
  logic        write_en;
  logic [31:0] write_data;
  logic        read_en;
  logic [31:0] read_data;
  logic        busywait;

  modport master (
    output addr, write_en, write_data, read_en,
    input  read_data, busywait
  );

  modport slave (
    input  addr, write_en, write_data, read_en,
    output read_data, busywait
  );
endinterface

// File: rtl/neuron_step_scheduler.sv
// Timestep sequencer: sole master of the neuron bank, stepping every neuron once per timestep.
// Define NEURON_SPIKE_COUNT_EN to add per-neuron saturating spike totals (spike_totals port).
module neuron_step_scheduler #(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned STEP_W      = 16,
  parameter int unsigned POLL_LIMIT  = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [STEP_W-1:0]      num_steps,
  input  logic                   cfg_mode,
  input  logic                   cur_we,
  input  logic [1:0]             cur_idx,
  input  logic [31:0]            cur_data,
  neuron_bank_if.master          bank,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout,
  output logic                   spike_valid,
  output logic [NUM_NEURONS-1:0] spike_vector,
  output logic [STEP_W-1:0]      step_count
`ifdef NEURON_SPIKE_COUNT_EN
  ,
  output logic [NUM_NEURONS*16-1:0] spike_totals
`endif
);

  localparam int unsigned      PollW     = $clog2(POLL_LIMIT + 1);
  localparam logic [PollW-1:0] PollLast  = PollW'(POLL_LIMIT - 1);
  localparam logic [1:0]       LastN     = 2'(NUM_NEURONS - 1);
  localparam logic [5:0]       OffI      = 6'h14;
  localparam logic [5:0]       OffCtrl   = 6'h18;
  localparam logic [5:0]       OffStatus = 6'h1C;

  typedef enum logic [2:0] {
    StIdle, StWrI, StTrig, StSettle, StPoll, StNext, StEmit
  } state_e;

  state_e                 state_q;
  logic [1:0]             n_q;
  logic [PollW-1:0]       poll_q;
  logic [STEP_W-1:0]      steps_q;
  logic [NUM_NEURONS-1:0] acc_q;
  logic [31:0]            cur_buf [NUM_NEURONS];
  logic                   unused_rd;

  assign unused_rd = ^bank.read_data[31:2];
  assign busy      = (state_q != StIdle);

  // Bus signals decode straight from state, so a stalled access holds naturally.
  always_comb begin
    bank.addr       = '0;
    bank.write_en   = 1'b0;
    bank.write_data = '0;
    bank.read_en    = 1'b0;
    unique case (state_q)
      StWrI: begin
        bank.addr       = {24'b0, n_q, OffI};
        bank.write_en   = 1'b1;
        bank.write_data = cur_buf[n_q];
      end
      StTrig: begin
        bank.addr       = {24'b0, n_q, OffCtrl};
        bank.write_en   = 1'b1;
        bank.write_data = {29'b0, cfg_mode, 2'b01};
      end
      StPoll: begin
        bank.addr    = {24'b0, n_q, OffStatus};
        bank.read_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      n_q          <= '0;
      poll_q       <= '0;
      steps_q      <= '0;
      acc_q        <= '0;
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      spike_valid  <= 1'b0;
      spike_vector <= '0;
      step_count   <= '0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) cur_buf[i] <= '0;
    end else begin
      done        <= 1'b0;
      spike_valid <= 1'b0;
      if (cur_we && (32'(cur_idx) < NUM_NEURONS)) cur_buf[cur_idx] <= cur_data;
      if (abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              steps_q <= num_steps;
              if (num_steps == '0) begin
                done <= 1'b1;
              end else begin
                step_count   <= '0;
                err_timeout  <= 1'b0;
                acc_q        <= '0;
                spike_vector <= '0;
                n_q          <= '0;
                poll_q       <= '0;
                state_q      <= StWrI;
              end
            end
          end
          StWrI:    if (!bank.busywait) state_q <= StTrig;
          StTrig:   if (!bank.busywait) state_q <= StSettle;
          StSettle: state_q <= StPoll;
          StPoll: begin
            if (!bank.busywait) begin
              poll_q <= poll_q + 1'b1;
              if (!bank.read_data[1]) begin
                acc_q[n_q] <= bank.read_data[0];
                state_q    <= StNext;
              end else if (poll_q == PollLast) begin
                err_timeout <= 1'b1;
                acc_q[n_q]  <= 1'b0;
                state_q     <= StNext;
              end
            end
          end
          StNext: begin
            poll_q <= '0;
            if (n_q == LastN) begin
              state_q <= StEmit;
            end else begin
              n_q     <= n_q + 1'b1;
              state_q <= StWrI;
            end
          end
          StEmit: begin
            spike_vector <= acc_q;
            spike_valid  <= 1'b1;
            step_count   <= step_count + STEP_W'(1);
            if ((step_count + STEP_W'(1)) == steps_q) begin
              done    <= 1'b1;
              state_q <= StIdle;
            end else begin
              n_q     <= '0;
              acc_q   <= '0;
              state_q <= StWrI;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef NEURON_SPIKE_COUNT_EN
  logic [15:0] tot_q [NUM_NEURONS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) tot_q[i] <= '0;
    end else if (!abort && (state_q == StIdle) && start) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) tot_q[i] <= '0;
    end else if (!abort && (state_q == StEmit)) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        if (acc_q[i] && (tot_q[i] != 16'hFFFF)) tot_q[i] <= tot_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    spike_totals = '0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) spike_totals[i*16 +: 16] = tot_q[i];
  end
`endif

endmodule

// File: doc/neuron_step_scheduler.md
Name: neuron_step_scheduler

Overview:
- Timestep sequencer that drives the memory-mapped neuron bank as its sole bus master.
- Each timestep, for every neuron in turn, it writes the input current, pulses Update, polls Status until the neuron is no longer busy, and captures the spike bit.
- Runs a host-programmed number of timesteps and emits one spike vector per timestep.
- Sits between the host/control plane and the neuron bank; replaces CPU-driven per-neuron polling.

Parameters:
- NUM_NEURONS, 4, neurons sequenced; 1..4 (bank decodes neuron at addr[7:6]).
- STEP_W, 16, width of timestep count/counter.
- POLL_LIMIT, 255, max Status reads per neuron before timeout error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; accepted only in IDLE
- abort  in  1  level; forces IDLE next cycle
- num_steps  in  STEP_W  timesteps to run, sampled at start
- cfg_mode  in  1  written to Control bit2 with every trigger
- cur_we  in  1  current buffer write enable
- cur_idx  in  2  current buffer index
- cur_data  in  32  current value
- bank_addr  out  32  bank address
- bank_write_en  out  1  bank write strobe
- bank_write_data  out  32  bank write data
- bank_read_en  out  1  bank read strobe
- bank_read_data  in  32  bank read data, combinational, same cycle
- bank_busywait  in  1  bank stall
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse after last timestep
- err_timeout  out  1  sticky until next accepted start
- spike_valid  out  1  one-cycle pulse per completed timestep
- spike_vector  out  NUM_NEURONS  bit n = spike of neuron n this timestep
- step_count  out  STEP_W  timesteps completed in current run

Behaviour:
- One clock (clk); synchronous active-high reset (rst). On reset: state IDLE; all outputs 0; current buffer 0; counters 0.
- Address: bank_addr = n*64 + offset. Offsets: 0x14 I, 0x18 Control, 0x1C Status. All other address bits 0.
- Current buffer: NUM_NEURONS x 32 regs, written any time when cur_we=1 (cur_idx >= NUM_NEURONS ignored). A WR_I read coinciding with a write to the same entry uses the old value.
- Bus rule: in any state asserting bank_write_en or bank_read_en, if bank_busywait=1 hold addr, data and enables, and stay in state. Read data is sampled only in a cycle with busywait=0.
- States:
  - IDLE: on start, latch num_steps. If num_steps==0, pulse done next cycle and stay IDLE. Else clear step_count, err_timeout and the spike accumulator, set n=0, go to WR_I.
  - WR_I: write cur_buf[n] to offset 0x14 -> TRIG.
  - TRIG: write {29'b0, cfg_mode, 1'b0, 1'b1} to 0x18 -> SETTLE.
  - SETTLE: no bus access for 1 cycle, to cover the bank's registered start pulse -> POLL.
  - POLL: read 0x1C; poll counter increments per completed read.
    - If bit1==0: spike_acc[n] <= bit0 -> NEXT.
    - Else if poll counter reaches POLL_LIMIT: set err_timeout, spike_acc[n] <= 0 -> NEXT.
  - NEXT: if n==NUM_NEURONS-1 -> EMIT; else n++, poll counter cleared -> WR_I.
  - EMIT: spike_vector <= spike_acc; spike_valid=1; step_count++.
    - If step_count+1==latched num_steps: done=1, go IDLE.
    - Else n=0, clear acc -> WR_I.
- Minimum latency: 4 + P cycles per neuron (P = polls, >=1), plus 1 EMIT cycle per timestep.
- spike_vector and step_count hold their values until the next EMIT or the next accepted start.
- abort: next cycle state=IDLE, bus enables 0, no done or spike_valid. A write in flight is dropped; the bank is left as-is.
- start while not IDLE: ignored. start and abort in the same cycle: abort wins.
- step_count wraps only if num_steps = 2^STEP_W - 1 is exceeded, which cannot occur.

Optional Feature:
- Macro NEURON_SPIKE_COUNT_EN.
- Defined:
  - Adds output spike_totals (NUM_NEURONS*16): per-neuron saturating 16-bit spike counters.
  - Counter n increments at EMIT when spike_vector bit n=1; saturates at 0xFFFF.
  - Cleared on rst and on accepted start.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Bank model, busy 3 cycles after Update; cur_buf={10,20,30,40}; num_steps=2; neurons 1,3 spike. Required: writes to 0x14/0x54/0x94/0xD4 with values 10/20/30/40; Control data 0x1; two spike_valid pulses with vector 4'b1010; step_count 1 then 2; done pulse once; busy low after.
- cfg_mode=1 -> every Control write data = 0x5.
- Neuron 2 never clears busy, POLL_LIMIT=4 -> exactly 4 Status reads of 0x9C; err_timeout=1; vector bit2=0; run continues to done.
- bank_busywait held 3 cycles during the TRIG write -> addr/data/enable stable for 4 cycles; exactly one effective write.
- abort during POLL of neuron 1 in step 0 -> IDLE next cycle; no spike_valid or done; a later start with num_steps=1 runs cleanly. Also: num_steps=0 -> done only, no bank access.
- rst asserted mid-run -> all outputs 0 next cycle; cur_buf cleared; with NEURON_SPIKE_COUNT_EN, 3 steps with neuron 0 spiking -> spike_totals[0]=3.
